// File: rtl/fcn_pkg.sv
// Shared types, default widths and the saturation helper for the FCN MAC array.
package fcn_pkg;

  localparam int LANES_DEF = 8;
  localparam int W_WGT_DEF = 8;
  localparam int W_ACT_DEF = 9;
  localparam int W_ACC_DEF = 24;
  localparam int W_OUT_DEF = 8;
  localparam int W_SH_DEF  = 5;

  // Working width of the saturation helper; every caller fits inside it.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_DRAIN,
    ST_OUT
  } state_t;

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                  input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_array_fcn_if.sv
// Beat input and result output handshakes of the FCN MAC array.
interface pe_array_fcn_if import fcn_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int W_WGT = W_WGT_DEF,
  parameter int W_ACT = W_ACT_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int W_SH  = W_SH_DEF
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [LANES*W_WGT-1:0]   in_wgt;
  logic [W_ACT-1:0]         in_act;
  logic [W_SH-1:0]          cfg_shift;
  logic                     cfg_relu;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*W_OUT-1:0]   out_data;
  logic [LANES-1:0]         out_ovf;

  modport master (
    output in_valid, in_last, in_wgt, in_act, cfg_shift, cfg_relu, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_last, in_wgt, in_act, cfg_shift, cfg_relu, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/fcn_mac_lane.sv
// One output neuron: product register, saturating accumulator, sticky overflow and requantiser.
module fcn_mac_lane import fcn_pkg::*; #(
  parameter int W_WGT = W_WGT_DEF,
  parameter int W_ACT = W_ACT_DEF,
  parameter int W_ACC = W_ACC_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int W_SH  = W_SH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_prod,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  input  logic                    load_out,
  input  logic signed [W_WGT-1:0] wgt,
  input  logic signed [W_ACT-1:0] act,
  input  logic [W_SH-1:0]         shift,
  input  logic                    relu,
  output logic signed [W_OUT-1:0] out_q,
  output logic                    ovf
);

  localparam int W_P = W_WGT + W_ACT;

  logic signed [W_P-1:0]   prod;
  logic signed [W_ACC-1:0] acc;
  logic signed [W_ACC-1:0] acc_sat;
  logic signed [W_ACC:0]   sum;
  logic signed [W_ACC:0]   rnd;
  logic signed [W_ACC:0]   rq_sum;
  logic signed [W_ACC:0]   rq_shift;
  logic signed [W_OUT-1:0] rq_val;
  logic                    sat_hit;

  // One guard bit catches any overflow of the accumulate before clamping.
  always_comb begin
    sum     = (W_ACC+1)'(acc) + (W_ACC+1)'(prod);
    acc_sat = W_ACC'(sat(SAT_W'(sum), W_ACC));
    sat_hit = ((W_ACC+1)'(acc_sat) != sum);
  end

  // NOTE: every variable gets a value on every path through always_comb, otherwise synthesis infers a latch.
  always_comb begin
    rnd = '0;
    if (shift != '0) rnd = (W_ACC+1)'(1) <<< (shift - W_SH'(1));
    rq_sum   = (W_ACC+1)'(acc) + rnd;
    rq_shift = rq_sum >>> shift;
    if (relu && rq_shift[W_ACC]) rq_shift = '0;
    rq_val = W_OUT'(sat(SAT_W'(rq_shift), W_OUT));
  end

  // NOTE: the product register is reset even though acc_en gates its use, so no X ever reaches the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else if (load_prod) begin
      prod <= W_P'(wgt) * W_P'(act);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (acc_clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (acc_en) begin
      acc <= acc_sat;
      if (sat_hit) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (load_out) begin
      out_q <= rq_val;
    end
  end

endmodule

// File: rtl/pe_array_fcn.sv
// Weight-stationary FCN MAC array: LANES lanes share one broadcast activation per beat.
module pe_array_fcn import fcn_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int W_WGT = W_WGT_DEF,
  parameter int W_ACT = W_ACT_DEF,
  parameter int W_ACC = W_ACC_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int W_SH  = W_SH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  pe_array_fcn_if.slave bus
);

  state_t          state;
  state_t          state_d;
  logic            s1_valid;
  logic            fire;
  logic            load_out;
  logic            acc_clr;
  logic [W_SH-1:0] shift_q;
  logic            relu_q;

  // in_ready is a pure function of state, so there is no path from out_ready.
  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = (state == ST_OUT);
  assign fire          = bus.in_valid & bus.in_ready & ~clr;
  assign acc_clr       = clr | (bus.out_valid & bus.out_ready);

  always_comb begin
    state_d  = state;
    load_out = 1'b0;
    unique case (state)
      ST_ACC:   if (fire && bus.in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_valid) begin
                  load_out = 1'b1;
                  state_d  = ST_OUT;
                end
      ST_OUT:   if (bus.out_ready) state_d = ST_ACC;
      default:  state_d = ST_ACC;
    endcase
    if (clr) begin
      state_d  = ST_ACC;
      load_out = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ACC;
      s1_valid <= 1'b0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
    end else begin
      state    <= state_d;
      s1_valid <= fire;
      if (fire && bus.in_last) begin
        shift_q <= bus.cfg_shift;
        relu_q  <= bus.cfg_relu;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fcn_mac_lane #(
      .W_WGT (W_WGT),
      .W_ACT (W_ACT),
      .W_ACC (W_ACC),
      .W_OUT (W_OUT),
      .W_SH  (W_SH)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_prod (fire),
      .acc_en    (s1_valid),
      .acc_clr   (acc_clr),
      .load_out  (load_out),
      .wgt       (bus.in_wgt[i*W_WGT +: W_WGT]),
      .act       (bus.in_act),
      .shift     (shift_q),
      .relu      (relu_q),
      .out_q     (bus.out_data[i*W_OUT +: W_OUT]),
      .ovf       (bus.out_ovf[i])
    );
  end

endmodule
